// File: rtl/isqrt_iter_fsm.sv
// Iterative 32-bit integer square root: bit-serial digit-by-digit method,
// one root bit per cycle, fixed 17-cycle latency from accept to result strobe.
module isqrt_iter_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] rad_q, rad_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [17:0] rem_sh;
  logic [17:0] trial;

  always_comb begin
    // The remainder never exceeds 2*root, so its top two bits are zero
    // whenever another pair of radicand bits is shifted in.
    rem_sh  = {rem_q[15:0], rad_q[31:30]};
    trial   = {root_q, 2'b01};

    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (x_vld) begin
          rad_d   = x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = 4'd15;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        rad_d = {rad_q[29:0], 2'b00};
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[14:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[14:0], 1'b0};
        end
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y_vld = (state_q == ST_DONE);
  assign busy  = (state_q == ST_CALC);
  assign y     = root_q;

endmodule

// File: doc/isqrt_iter_fsm.md
ISQRT_ITER_FSM -- requirements
Module: isqrt_iter_fsm

Interface
REQ-001 SHALL have ports, clock and reset first:
  clk    input   1   clock; all state changes on rising edge
  rst    input   1   reset, synchronous, active-high
  x_vld  input   1   request strobe; x is sampled when an accepted x_vld is high; one-cycle pulse suffices
  x      input   32  unsigned radicand
  y_vld  output  1   one-cycle result strobe
  y      output  16  unsigned floor(sqrt(x))
  busy   output  1   high while a computation is in flight
REQ-002 SHALL have no parameters; all widths fixed as listed.

Function
REQ-003 SHALL compute y = floor(sqrt(x)) exactly for every 32-bit x, using bit-serial digit-by-digit square root, one result bit per cycle.
REQ-004 SHALL use three states: ST_IDLE, ST_CALC, ST_DONE.
REQ-005 SHALL accept a request when x_vld=1 in ST_IDLE or ST_DONE:
  - load radicand shift register with x
  - clear remainder and root
  - set iteration counter to 15
  - go to ST_CALC.
REQ-006 SHALL ignore x_vld while in ST_CALC, with no effect on the computation in flight.
REQ-007 SHALL perform exactly one iteration per cycle in ST_CALC:
  - rem = (rem<<2) | top two radicand bits; radicand <<= 2
  - trial = (root<<2) | 1
  - rem >= trial: rem -= trial, root = (root<<1)|1
  - otherwise: root = root<<1.
REQ-008 SHALL size rem and trial at 18 bits so no intermediate overflows, and root at 16 bits.
REQ-009 SHALL go from ST_CALC to ST_DONE on the edge that completes the iteration with counter = 0, for exactly 16 iterations per request.
REQ-010 SHALL fix latency: x_vld accepted on the edge ending cycle k -> y_vld=1 during cycle k+17 exactly.
  - Two instances started in the same cycle therefore return results in the same cycle.
REQ-011 SHALL assert y_vld=1 only in ST_DONE, for exactly one cycle per request.
REQ-012 SHALL go from ST_DONE to ST_IDLE when x_vld=0, or to ST_CALC when x_vld=1 (back-to-back accept).
  - This gives a sustained throughput of one result per 17 cycles.
REQ-013 SHALL drive y from the root register:
  - y is valid whenever y_vld=1
  - y holds the last result until the next ST_DONE
  - y changes only during ST_CALC iterations.
REQ-014 SHALL drive busy = 1 exactly when in ST_CALC; busy is 0 in ST_IDLE and ST_DONE.
REQ-015 SHALL register all outputs (Moore outputs decoded from state/registers only), with no combinational path from x or x_vld to any output.

Reset
REQ-016 SHALL, on rst=1 at a rising edge:
  - go to ST_IDLE
  - drive y_vld=0, busy=0, y=0
  - clear the counter, remainder and radicand registers.
REQ-017 SHALL abort a computation in flight when rst is asserted mid-operation; no y_vld follows for that request.
REQ-018 SHALL give rst priority over a simultaneous x_vld; that x_vld is dropped.

Verification
REQ-019 Single values, one pulse each, idle between:
  - x=0 -> y=0
  - x=1 -> y=1
  - x=15 -> y=3
  - x=16 -> y=4
  - x=1000000 -> y=1000
  - x=0xFFFFFFFF -> y=0xFFFF
  - For each, y_vld is seen exactly 17 cycles after the x_vld cycle.
REQ-020 Ignored request: x=100 accepted, x=49 pulsed at cycle +5 -> single y_vld at +17 with y=10, no second y_vld.
REQ-021 Back-to-back: x=81 accepted, x=144 pulsed in the y_vld cycle of the first -> y=9, then y=12 exactly 17 cycles later.
REQ-022 Reset mid-op: x=65536 accepted, rst pulsed at cycle +8:
  - no y_vld; y=0, busy=0 after reset
  - then x=4 -> y=2 at +17.
REQ-023 Two instances started in the same cycle with x=0x40000000 and x=2 -> y_vld high together, y=0x8000 and y=1.
REQ-024 Random: 10000 random x, including 0xFFFE0001 (y=0xFFFF) and 0xFFFE0000 (y=0xFFFE) -> y matches the integer reference floor(sqrt(x)) for every case.
